// File: rtl/cvo_pkg.sv
// cvo_pkg: shared FSM state type and raster sizing helpers for the clocked-video output path.
package cvo_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } cvo_state_e;

  // Narrowest counter any raster may use; real widths come from cnt_width().
  localparam int unsigned CVO_MIN_CNT_W = 1;

  // Total length of one raster axis: active + front porch + sync + back porch.
  function automatic int unsigned raster_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned total);
    return (total > (2 ** CVO_MIN_CNT_W)) ? $clog2(total) : CVO_MIN_CNT_W;
  endfunction

endpackage

// File: rtl/cvo_raster_cnt.sv
// cvo_raster_cnt: free-running hcnt/vcnt raster counters with decoded active, sync and frame-start flags.
module cvo_raster_cnt
  import cvo_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  localparam int unsigned H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned H_W     = cnt_width(H_TOTAL),
  localparam int unsigned V_W     = cnt_width(V_TOTAL)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [H_W-1:0] hcnt,
  output logic [V_W-1:0] vcnt,
  output logic           h_active_c,
  output logic           v_active_c,
  output logic           active_c,
  output logic           h_sync_c,
  output logic           v_sync_c,
  output logic           frame_start_c
);

  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic h_last;
  logic v_last;

  assign h_last = (hcnt == H_W'(H_TOTAL - 1));
  assign v_last = (vcnt == V_W'(V_TOTAL - 1));

  // Line counter advances only when the pixel counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + V_W'(1);
    end else begin
      hcnt <= hcnt + H_W'(1);
    end
  end

  assign h_active_c    = (hcnt < H_W'(H_ACTIVE));
  assign v_active_c    = (vcnt < V_W'(V_ACTIVE));
  assign active_c      = h_active_c & v_active_c;
  assign h_sync_c      = (hcnt >= H_W'(HS_START)) && (hcnt < H_W'(HS_END));
  assign v_sync_c      = (vcnt >= V_W'(VS_START)) && (vcnt < V_W'(VS_END));
  assign frame_start_c = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/cvo_raster_out.sv
// cvo_raster_out: clocked-video output stage locking an Avalon-ST pixel stream onto a free-running raster.
// Optional feature: define CVO_UNDERFLOW_RESYNC_EN to return to SEARCH on the first starved pixel while locked.
module cvo_raster_out
  import cvo_pkg::*;
#(
  parameter int unsigned PIXEL_W  = 32,
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  localparam int unsigned H_W     = cnt_width(raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  localparam int unsigned V_W     = cnt_width(raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic               vid_clk,
  input  logic               vid_reset_n,
  input  logic [PIXEL_W-1:0] din_data,
  input  logic               din_valid,
  input  logic               din_sop,
  input  logic               din_eop,
  output logic               din_ready,
  output logic [PIXEL_W-1:0] vid_data,
  output logic               vid_datavalid,
  output logic               vid_h_sync,
  output logic               vid_v_sync,
  output logic               vid_h,
  output logic               vid_v,
  output logic               vid_f,
  output logic               underflow,
  output logic               locked
);

  logic [H_W-1:0] hcnt_unused;
  logic [V_W-1:0] vcnt_unused;
  logic           h_active_c;
  logic           v_active_c;
  logic           active_c;
  logic           h_sync_c;
  logic           v_sync_c;
  logic           frame_start_c;

  cvo_state_e     state;
  cvo_state_e     state_d;
  logic           ready_c;
  logic           take_c;
  logic           starve_c;
  logic           head_sop_c;
  logic           early_sop_c;

  // Frame length comes from the raster parameters, so eop carries no information here.
  logic           eop_unused;
  assign eop_unused = din_eop;

  cvo_raster_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_raster (
    .clk           (vid_clk),
    .rst_n         (vid_reset_n),
    .hcnt          (hcnt_unused),
    .vcnt          (vcnt_unused),
    .h_active_c    (h_active_c),
    .v_active_c    (v_active_c),
    .active_c      (active_c),
    .h_sync_c      (h_sync_c),
    .v_sync_c      (v_sync_c),
    .frame_start_c (frame_start_c)
  );

  assign head_sop_c  = din_valid & din_sop;
  // A new frame arriving mid-raster is left at the head and re-aligned at the next frame start.
  assign early_sop_c = head_sop_c & active_c & ~frame_start_c;

  always_ff @(posedge vid_clk or negedge vid_reset_n) begin
    if (!vid_reset_n) begin
      state <= SEARCH;
    end else begin
      state <= state_d;
    end
  end

  // Next state, stream handshake and per-cycle pixel decision.
  always_comb begin
    state_d  = state;
    ready_c  = 1'b0;
    take_c   = 1'b0;
    starve_c = 1'b0;
    unique case (state)
      SEARCH: begin
        ready_c = ~head_sop_c;
        if (head_sop_c) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        ready_c = frame_start_c & head_sop_c;
        take_c  = ready_c;
        if (ready_c) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        ready_c  = active_c & ~early_sop_c;
        take_c   = ready_c & din_valid;
        starve_c = active_c & ~din_valid;
        if (early_sop_c) begin
          state_d = ARMED;
        end
`ifdef CVO_UNDERFLOW_RESYNC_EN
        else if (starve_c) begin
          state_d = SEARCH;
        end
`endif
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  assign din_ready = ready_c & vid_reset_n;

  // Video bus lags the raster counters by one cycle; pixel and controls stay aligned.
  always_ff @(posedge vid_clk or negedge vid_reset_n) begin
    if (!vid_reset_n) begin
      vid_data      <= '0;
      vid_datavalid <= 1'b0;
      vid_h_sync    <= ~HS_POL;
      vid_v_sync    <= ~VS_POL;
      vid_h         <= 1'b1;
      vid_v         <= 1'b1;
      vid_f         <= 1'b0;
      underflow     <= 1'b0;
      locked        <= 1'b0;
    end else begin
      vid_data      <= take_c ? din_data : '0;
      vid_datavalid <= active_c;
      vid_h_sync    <= h_sync_c ? HS_POL : ~HS_POL;
      vid_v_sync    <= v_sync_c ? VS_POL : ~VS_POL;
      vid_h         <= ~h_active_c;
      vid_v         <= ~v_active_c;
      vid_f         <= 1'b0;
      underflow     <= starve_c;
      locked        <= (state_d == LOCKED);
    end
  end

endmodule

// File: tb/tb_cvo_raster_out.sv
// tb_cvo_raster_out: directed bench for cvo_raster_out in a 7x6 raster, with a per-cycle reference model.
module tb_cvo_raster_out;

  localparam int HA = 4, HF = 1, HSY = 1, HB = 1;
  localparam int VA = 3, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;
  localparam int LOGN = 200;
  localparam int HUNT = 0, WAIT = 1, TRACK = 2;

  typedef struct packed {
    logic        valid;
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } beat_t;

  logic        vid_clk = 1'b0;
  logic        vid_reset_n = 1'b1;
  logic [31:0] din_data = '0;
  logic        din_valid = 1'b0;
  logic        din_sop = 1'b0;
  logic        din_eop = 1'b0;

  logic        a_rdy, a_dv, a_hs, a_vs, a_h, a_v, a_f, a_uf, a_lk;
  logic [31:0] a_data;
  logic        b_rdy, b_dv, b_hs, b_vs, b_h, b_v, b_f, b_uf, b_lk;
  logic [31:0] b_data;

  cvo_raster_out #(
    .PIXEL_W(32), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut (
    .vid_clk(vid_clk), .vid_reset_n(vid_reset_n), .din_data(din_data),
    .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop), .din_ready(a_rdy),
    .vid_data(a_data), .vid_datavalid(a_dv), .vid_h_sync(a_hs), .vid_v_sync(a_vs),
    .vid_h(a_h), .vid_v(a_v), .vid_f(a_f), .underflow(a_uf), .locked(a_lk)
  );

  cvo_raster_out #(
    .PIXEL_W(32), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut_pol (
    .vid_clk(vid_clk), .vid_reset_n(vid_reset_n), .din_data(din_data),
    .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop), .din_ready(b_rdy),
    .vid_data(b_data), .vid_datavalid(b_dv), .vid_h_sync(b_hs), .vid_v_sync(b_vs),
    .vid_h(b_h), .vid_v(b_v), .vid_f(b_f), .underflow(b_uf), .locked(b_lk)
  );

  always #5 vid_clk = ~vid_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pos = 0;
  int mode = HUNT;
  beat_t sq[$];

  logic [31:0] out_log [LOGN];
  logic        lock_log[LOGN];
  logic        uf_log  [LOGN];
  logic        hs_log  [LOGN];
  logic        vs_log  [LOGN];
  logic        rdy_log [LOGN];

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Queue one input frame of n pixels; gap_at >= 0 inserts a one-cycle bubble before that pixel.
  task automatic push_frame(input logic [31:0] base, input int n, input int gap_at);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        b = '0;
        sq.push_back(b);
      end
      b.valid = 1'b1;
      b.sop   = (i == 0);
      b.eop   = (i == n - 1);
      b.data  = base + 32'(i);
      sq.push_back(b);
    end
  endtask

  task automatic push_junk(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.valid = 1'b1;
      b.sop   = 1'b0;
      b.eop   = 1'b0;
      b.data  = 32'hDEAD_0000 + 32'(i);
      sq.push_back(b);
    end
  endtask

  // Assert reset mid-cycle, check the asynchronous reset values, then release on a falling edge.
  task automatic do_reset();
    #2;
    vid_reset_n = 1'b0;
    din_valid   = 1'b1;
    din_sop     = 1'b0;
    din_data    = 32'hFFFF_FFFF;
    #1;
    check_word("rst_vid_data", a_data, 32'h0);
    check_bit("rst_datavalid", a_dv, 1'b0);
    check_bit("rst_vid_h", a_h, 1'b1);
    check_bit("rst_vid_v", a_v, 1'b1);
    check_bit("rst_vid_f", a_f, 1'b0);
    check_bit("rst_h_sync", a_hs, 1'b1);
    check_bit("rst_v_sync", a_vs, 1'b1);
    check_bit("rst_underflow", a_uf, 1'b0);
    check_bit("rst_locked", a_lk, 1'b0);
    check_bit("rst_din_ready", a_rdy, 1'b0);
    check_bit("rst_pol_h_sync", b_hs, 1'b0);
    check_bit("rst_pol_v_sync", b_vs, 1'b0);
    repeat (2) @(posedge vid_clk);
    @(negedge vid_clk);
    vid_reset_n = 1'b1;
    sq.delete();
    pos  = 0;
    mode = HUNT;
    cyc  = 0;
    for (int i = 0; i < LOGN; i++) begin
      out_log[i] = '0; lock_log[i] = 1'b0; uf_log[i] = 1'b0;
      hs_log[i] = 1'b0; vs_log[i] = 1'b0; rdy_log[i] = 1'b0;
    end
  endtask

  // One raster cycle: present the stream head, predict from the raster position, compare both DUTs.
  task automatic step();
    int h, v, nmode;
    logic act, fs, head_sop, early, m_ready, m_take, m_starve, hs_on, vs_on;
    logic [31:0] m_data;
    if (sq.size() > 0) begin
      din_valid = sq[0].valid; din_sop = sq[0].sop; din_eop = sq[0].eop; din_data = sq[0].data;
    end else begin
      din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_data = '0;
    end
    h = pos % HT;
    v = pos / HT;
    act   = (h < HA) && (v < VA);
    fs    = (pos == 0);
    hs_on = (h >= HA + HF) && (h < HA + HF + HSY);
    vs_on = (v >= VA + VF) && (v < VA + VF + VSY);
    head_sop = din_valid && din_sop;
    m_ready = 1'b0; m_take = 1'b0; m_starve = 1'b0; early = 1'b0;
    nmode = mode;
    if (mode == HUNT) begin
      m_ready = !head_sop;
      if (head_sop) nmode = WAIT;
    end else if (mode == WAIT) begin
      m_ready = fs && head_sop;
      m_take  = m_ready;
      if (m_take) nmode = TRACK;
    end else begin
      early    = head_sop && act && !fs;
      m_ready  = act && !early;
      m_take   = m_ready && din_valid;
      m_starve = act && !din_valid;
      if (early) nmode = WAIT;
`ifdef CVO_UNDERFLOW_RESYNC_EN
      else if (m_starve) nmode = HUNT;
`endif
    end
    m_data = m_take ? din_data : 32'h0;
    #1;
    check_bit("din_ready", a_rdy, m_ready);
    check_bit("pol_din_ready", b_rdy, m_ready);
    if (cyc < LOGN) rdy_log[cyc] = a_rdy;
    @(posedge vid_clk);
    #1;
    check_word("vid_data", a_data, m_data);
    check_bit("vid_datavalid", a_dv, act);
    check_bit("vid_h", a_h, !(h < HA));
    check_bit("vid_v", a_v, !(v < VA));
    check_bit("vid_f", a_f, 1'b0);
    check_bit("vid_h_sync", a_hs, !hs_on);
    check_bit("vid_v_sync", a_vs, !vs_on);
    check_bit("underflow", a_uf, m_starve);
    check_bit("locked", a_lk, nmode == TRACK);
    check_word("pol_vid_data", b_data, m_data);
    check_bit("pol_datavalid", b_dv, act);
    check_bit("pol_vid_h", b_h, !(h < HA));
    check_bit("pol_vid_v", b_v, !(v < VA));
    check_bit("pol_vid_f", b_f, 1'b0);
    check_bit("pol_h_sync", b_hs, hs_on);
    check_bit("pol_v_sync", b_vs, vs_on);
    check_bit("pol_underflow", b_uf, m_starve);
    check_bit("pol_locked", b_lk, nmode == TRACK);
    if (cyc < LOGN) begin
      out_log[cyc] = a_data; lock_log[cyc] = a_lk; uf_log[cyc] = a_uf;
      hs_log[cyc] = a_hs; vs_log[cyc] = a_vs;
    end
    if (sq.size() > 0 && (!sq[0].valid || m_ready)) void'(sq.pop_front());
    mode = nmode;
    pos  = (pos + 1) % FRAME;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int cnt;

    // Junk before sop, then continuous frames.
    do_reset();
    push_junk(5);
    push_frame(32'h1000, 12, -1);
    push_frame(32'h2000, 12, -1);
    push_frame(32'h3000, 12, -1);
    repeat (160) step();
    cnt = 0;
    for (int i = 0; i < 5; i++) cnt += int'(rdy_log[i]);
    check_word("junk_ready_cycles", 32'(cnt), 32'd5);
    check_bit("lit_unlocked_41", lock_log[41], 1'b0);
    check_bit("lit_locked_42", lock_log[42], 1'b1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        check_word("lit_frame_pixel", out_log[42 + r * 7 + c], 32'h1000 + 32'(r * 4 + c));
    check_word("lit_frame2_first", out_log[84], 32'h2000);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) cnt += int'(!hs_log[i]);
    check_word("lit_hsync_low_cycles", 32'(cnt), 32'd6);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) cnt += int'(!vs_log[i]);
    check_word("lit_vsync_low_cycles", 32'(cnt), 32'd7);
    check_bit("lit_hsync_at_h5", hs_log[5], 1'b0);
    check_bit("lit_vsync_line4", vs_log[28], 1'b0);

    // Starved pixel (1,2) in a locked frame.
    do_reset();
    push_frame(32'h4000, 12, 6);
    push_frame(32'h5000, 12, -1);
    push_frame(32'h6000, 12, -1);
    repeat (168) step();
    check_bit("lit_underflow_pulse", uf_log[51], 1'b1);
    check_word("lit_starved_black", out_log[51], 32'h0);
    cnt = 0;
    for (int i = 0; i < 168; i++) cnt += int'(uf_log[i]);
    check_word("lit_underflow_count", 32'(cnt), 32'd1);
`ifdef CVO_UNDERFLOW_RESYNC_EN
    check_bit("lit_lock_lost", lock_log[51], 1'b0);
    check_word("lit_after_starve", out_log[52], 32'h0);
    check_word("lit_relock_pixel", out_log[84], 32'h5000);
`else
    check_bit("lit_lock_kept", lock_log[51], 1'b1);
    check_word("lit_after_starve", out_log[52], 32'h4006);
    check_word("lit_relock_pixel", out_log[126], 32'h5000);
`endif

    // Early sop at pixel (0,2).
    do_reset();
    push_frame(32'h7000, 2, -1);
    push_frame(32'h8000, 12, -1);
    push_frame(32'h9000, 12, -1);
    repeat (126) step();
    check_word("lit_pixel_01", out_log[43], 32'h7001);
    check_word("lit_early_sop_black", out_log[44], 32'h0);
    check_bit("lit_early_sop_unlock", lock_log[44], 1'b0);
    check_word("lit_held_sop_pixel", out_log[84], 32'h8000);
    check_bit("lit_relocked", lock_log[84], 1'b1);

    // Reset mid-line while locked, then restart from 0,0.
    do_reset();
    push_frame(32'hA000, 12, -1);
    push_frame(32'hB000, 12, -1);
    repeat (50) step();
    check_word("lit_pre_reset_pixel", out_log[49], 32'hA004);
    do_reset();
    push_frame(32'hC000, 12, -1);
    push_frame(32'hD000, 12, -1);
    repeat (60) step();
    check_word("lit_restart_pixel0", out_log[42], 32'hC000);
    check_word("lit_restart_pixel1", out_log[43], 32'hC001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
